// File: rtl/conv_mac_sched_pkg.sv
// conv_pkg: state encoding, default geometry and output-count helper shared by
// the convolution MAC sequencer and its window counter.
package conv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      ACC,
      DRAIN,
      OUT,
      DONE
   } state_e;

   localparam int DEF_INW  = 16;
   localparam int DEF_OUTW = 64;
   localparam int DEF_R    = 8;
   localparam int DEF_C    = 8;
   localparam int DEF_K    = 3;

   function automatic int num_outputs(input int r, input int c, input int k);
      return (r - k + 1) * (c - k + 1);
   endfunction

endpackage

// File: rtl/conv_mac_sched_win_cnt.sv
// conv_win_cnt: nested kernel-tap counter (kr/kc) and output-position counter
// (orow/ocol) with last-tap/last-position flags and SRAM address generation.
module conv_win_cnt
   import conv_pkg::*;
#(
   parameter int R   = DEF_R,
   parameter int C   = DEF_C,
   parameter int K   = DEF_K,
   parameter int XAW = 6,
   parameter int WAW = 4,
   parameter int KW  = 2,
   parameter int ORW = 3,
   parameter int OCW = 3
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           pos_clr_i,
   input  logic           pos_adv_i,
   input  logic           tap_clr_i,
   input  logic           tap_adv_i,
   output logic           last_tap_o,
   output logic           last_pos_o,
   output logic [ORW-1:0] orow_o,
   output logic [OCW-1:0] ocol_o,
   output logic [XAW-1:0] x_addr_o,
   output logic [WAW-1:0] w_addr_o
);

   localparam logic [KW-1:0]  KLAST = KW'(K - 1);
   localparam logic [ORW-1:0] RLAST = ORW'(R - K);
   localparam logic [OCW-1:0] CLAST = OCW'(C - K);
   localparam int unsigned    CU    = C;
   localparam int unsigned    KU    = K;

   logic [KW-1:0]  kr_q, kc_q;
   logic [ORW-1:0] orow_q;
   logic [OCW-1:0] ocol_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         kr_q <= '0;
         kc_q <= '0;
      end else if (tap_clr_i) begin
         kr_q <= '0;
         kc_q <= '0;
      end else if (tap_adv_i) begin
         if (kc_q == KLAST) begin
            kc_q <= '0;
            kr_q <= (kr_q == KLAST) ? '0 : kr_q + KW'(1);
         end else begin
            kc_q <= kc_q + KW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         orow_q <= '0;
         ocol_q <= '0;
      end else if (pos_clr_i) begin
         orow_q <= '0;
         ocol_q <= '0;
      end else if (pos_adv_i) begin
         if (ocol_q == CLAST) begin
            ocol_q <= '0;
            orow_q <= (orow_q == RLAST) ? '0 : orow_q + ORW'(1);
         end else begin
            ocol_q <= ocol_q + OCW'(1);
         end
      end
   end

   always_comb begin
      last_tap_o = (kr_q == KLAST) && (kc_q == KLAST);
      last_pos_o = (orow_q == RLAST) && (ocol_q == CLAST);
      orow_o     = orow_q;
      ocol_o     = ocol_q;
      x_addr_o   = XAW'((32'(orow_q) + 32'(kr_q)) * CU + 32'(ocol_q) + 32'(kc_q));
      w_addr_o   = WAW'(32'(kr_q) * KU + 32'(kc_q));
   end

endmodule

// File: rtl/conv_mac_sched.sv
// conv_mac_sched: sequences one signed MAC over a valid-mode K x K convolution
// of an R x C image. Optional ReLU on the result via `CONV_SCHED_RELU_EN.
module conv_mac_sched
   import conv_pkg::*;
#(
   parameter int INW  = DEF_INW,
   parameter int OUTW = DEF_OUTW,
   parameter int R    = DEF_R,
   parameter int C    = DEF_C,
   parameter int K    = DEF_K,
   parameter int XAW  = ($clog2(R * C) > 0) ? $clog2(R * C) : 1,
   parameter int WAW  = ($clog2(K * K) > 0) ? $clog2(K * K) : 1,
   localparam int ORW = ($clog2(R - K + 1) > 0) ? $clog2(R - K + 1) : 1,
   localparam int OCW = ($clog2(C - K + 1) > 0) ? $clog2(C - K + 1) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [OUTW-1:0] bias,
   output logic            busy,
   output logic            done,
   output logic [XAW-1:0]  x_addr,
   output logic [WAW-1:0]  w_addr,
   output logic            rd_en,
   output logic            mac_init_acc,
   output logic [OUTW-1:0] mac_init_value,
   output logic            mac_input_valid,
   input  logic [OUTW-1:0] mac_out,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [OUTW-1:0] out_data,
   output logic [ORW-1:0]  out_row,
   output logic [OCW-1:0]  out_col
);

   localparam int KW = (K > 1) ? $clog2(K) : 1;

   if (OUTW < 2 * INW) begin : g_width_chk
      $error("conv_mac_sched: OUTW must hold a full INW x INW product");
   end

   state_e          state_q;
   logic [OUTW-1:0] bias_q;
   logic            busy_q, done_q, rd_en_q, init_acc_q, in_valid_q, out_valid_q;
   logic            last_tap, last_pos;
   logic            pos_clr, pos_adv, tap_clr, tap_adv;
   logic [OUTW-1:0] result_d;

   assign pos_clr = (state_q == IDLE) && start;
   assign pos_adv = (state_q == OUT) && out_ready;
   assign tap_clr = (state_q == INIT);
   assign tap_adv = (state_q == ACC);

   conv_win_cnt #(
      .R  (R),
      .C  (C),
      .K  (K),
      .XAW(XAW),
      .WAW(WAW),
      .KW (KW),
      .ORW(ORW),
      .OCW(OCW)
   ) u_win_cnt (
      .clk_i     (clk),
      .rst_i     (reset),
      .pos_clr_i (pos_clr),
      .pos_adv_i (pos_adv),
      .tap_clr_i (tap_clr),
      .tap_adv_i (tap_adv),
      .last_tap_o(last_tap),
      .last_pos_o(last_pos),
      .orow_o    (out_row),
      .ocol_o    (out_col),
      .x_addr_o  (x_addr),
      .w_addr_o  (w_addr)
   );

   // Outputs are registered alongside the state: each branch sets what the
   // next state drives, so mac_input_valid trails rd_en by exactly one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         bias_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         init_acc_q  <= 1'b0;
         in_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         init_acc_q <= 1'b0;
         in_valid_q <= rd_en_q;
         case (state_q)
            IDLE: begin
               if (start) begin
                  bias_q     <= bias;
                  busy_q     <= 1'b1;
                  init_acc_q <= 1'b1;
                  state_q    <= INIT;
               end
            end
            INIT: begin
               rd_en_q <= 1'b1;
               state_q <= ACC;
            end
            ACC: begin
               if (last_tap) begin
                  rd_en_q <= 1'b0;
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               out_valid_q <= 1'b1;
               state_q     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (last_pos) begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     init_acc_q <= 1'b1;
                     state_q    <= INIT;
                  end
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      result_d = mac_out;
`ifdef CONV_SCHED_RELU_EN
      if (mac_out[OUTW-1]) result_d = '0;
`endif
      out_data = out_valid_q ? result_d : '0;
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign rd_en           = rd_en_q;
   assign mac_init_acc    = init_acc_q;
   assign mac_init_value  = bias_q;
   assign mac_input_valid = in_valid_q;
   assign out_valid       = out_valid_q;

endmodule

// File: tb/tb_conv_mac_sched.sv
// Bench for conv_mac_sched: behavioural SRAMs and MAC around two instances
// (4x4 image / 3x3 kernel, and 2x2 image / 1x1 kernel), checked against a direct convolution.
module tb_conv_mac_sched;

   localparam int R1 = 4, C1 = 4, K1 = 3;

   logic        clk = 1'b0, reset = 1'b1;
   logic        start = 1'b0, out_ready = 1'b1;
   logic [63:0] bias = '0;
   logic        busy, done, rd_en, mac_init_acc, mac_input_valid, out_valid;
   logic [3:0]  x_addr, w_addr;
   logic [63:0] mac_init_value, out_data;
   logic [63:0] mac_out = '0;
   logic [0:0]  out_row, out_col;

   logic        start2 = 1'b0, out_ready2 = 1'b1;
   logic [63:0] bias2 = '0;
   logic        busy2, done2, rd_en2, mac_init_acc2, mac_input_valid2, out_valid2;
   logic [1:0]  x_addr2;
   logic [0:0]  w_addr2;
   logic [63:0] mac_init_value2, out_data2;
   logic [63:0] mac_out2 = '0;
   logic [0:0]  out_row2, out_col2;

   logic signed [15:0] img [16];
   logic signed [15:0] wgt [9];
   logic signed [15:0] img2 [4];
   logic signed [15:0] wgt2 [1];
   logic signed [15:0] xrd, wrd, xrd2, wrd2;

   int total = 0, bad = 0;

   longint got_d[$];
   int     got_r[$], got_c[$];
   int     done_cnt, done_cyc, rd_cnt, rd_stall;
   bit     tmo, stab_err;

   always #5 clk = ~clk;

   conv_mac_sched #(.INW(16), .OUTW(64), .R(R1), .C(C1), .K(K1)) dut (
      .clk(clk), .reset(reset), .start(start), .bias(bias), .busy(busy), .done(done),
      .x_addr(x_addr), .w_addr(w_addr), .rd_en(rd_en), .mac_init_acc(mac_init_acc),
      .mac_init_value(mac_init_value), .mac_input_valid(mac_input_valid), .mac_out(mac_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row(out_row), .out_col(out_col)
   );

   conv_mac_sched #(.INW(16), .OUTW(64), .R(2), .C(2), .K(1)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .bias(bias2), .busy(busy2), .done(done2),
      .x_addr(x_addr2), .w_addr(w_addr2), .rd_en(rd_en2), .mac_init_acc(mac_init_acc2),
      .mac_init_value(mac_init_value2), .mac_input_valid(mac_input_valid2), .mac_out(mac_out2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
      .out_row(out_row2), .out_col(out_col2)
   );

   function automatic logic [63:0] prod(input logic signed [15:0] a, input logic signed [15:0] b);
      longint pa, pb;
      pa = a;
      pb = b;
      return pa * pb;
   endfunction

   // Registered-read SRAMs and an init/accumulate MAC.
   always @(posedge clk) begin
      if (rd_en) begin xrd <= img[x_addr]; wrd <= wgt[w_addr]; end
      if (mac_init_acc) mac_out <= mac_init_value;
      else if (mac_input_valid) mac_out <= mac_out + prod(xrd, wrd);
      if (rd_en2) begin xrd2 <= img2[x_addr2]; wrd2 <= wgt2[w_addr2]; end
      if (mac_init_acc2) mac_out2 <= mac_init_value2;
      else if (mac_input_valid2) mac_out2 <= mac_out2 + prod(xrd2, wrd2);
   end

   function automatic longint ref_pix(input int orow, input int ocol, input longint b);
      longint s;
      s = b;
      for (int kr = 0; kr < K1; kr++)
         for (int kc = 0; kc < K1; kc++)
            s += longint'(img[(orow + kr) * C1 + ocol + kc]) * longint'(wgt[kr * K1 + kc]);
`ifdef CONV_SCHED_RELU_EN
      if (s < 0) s = 0;
`endif
      return s;
   endfunction

   task automatic load_random();
      for (int i = 0; i < 16; i++) img[i] = 16'($urandom);
      for (int i = 0; i < 9; i++) wgt[i] = 16'($urandom);
   endtask

   // mode 0: ready always high; 1: random ready; 2: hold ready low 5 cycles on the 2nd output
   task automatic run_frame(input int mode, input bit hold, input longint b);
      int cyc, stall;
      logic [63:0] sd;
      logic [0:0]  sr, sc;
      got_d.delete(); got_r.delete(); got_c.delete();
      done_cnt = 0; done_cyc = -1; rd_cnt = 0; rd_stall = 0;
      tmo = 1; stab_err = 0; stall = 0; cyc = 0;
      sd = '0; sr = '0; sc = '0;
      bias = b;
      start = 1'b1;
      for (int n = 0; n < 600; n++) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) bias = {$urandom, $urandom};
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (!hold || done_cyc >= 0) start = 1'b0;
         if (rd_en) rd_cnt++;
         out_ready = 1'b1;
         if (mode == 1) out_ready = ($urandom_range(0, 2) != 0);
         if (mode == 2 && out_valid && got_d.size() == 1 && stall < 5) begin
            out_ready = 1'b0;
            if (rd_en) rd_stall++;
            if (stall == 0) {sd, sr, sc} = {out_data, out_row, out_col};
            else if ({out_valid, out_data, out_row, out_col} !== {1'b1, sd, sr, sc}) stab_err = 1;
            stall++;
         end
         if (out_valid && out_ready) begin
            got_d.push_back(longint'(out_data));
            got_r.push_back(int'(out_row));
            got_c.push_back(int'(out_col));
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 4) begin
            tmo = 0;
            break;
         end
      end
      start = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      total++;
      if ({busy, done, rd_en, mac_init_acc, mac_input_valid, out_valid} !== 6'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got %b expected 000000",
                  {busy, done, rd_en, mac_init_acc, mac_input_valid, out_valid});
      end
      total++;
      if ({x_addr, w_addr, out_row, out_col} !== 10'b0) begin
         bad++;
         $display("FAIL reset_idx: got %h expected 0", {x_addr, w_addr, out_row, out_col});
      end
      total++;
      if ({out_data, mac_init_value} !== 128'b0) begin
         bad++;
         $display("FAIL reset_data: got %h/%h expected 0/0", out_data, mac_init_value);
      end
   endtask

   task automatic test_ones();
      for (int i = 0; i < 16; i++) img[i] = 16'sd1;
      for (int i = 0; i < 9; i++) wgt[i] = 16'sd1;
      run_frame(0, 0, 0);
      total++;
      if (tmo) begin bad++; $display("FAIL ones_timeout: got no done expected done"); end
      total++;
      if (got_d.size() != 4) begin bad++; $display("FAIL ones_count: got %0d expected 4", got_d.size()); end
      for (int i = 0; i < got_d.size() && i < 4; i++) begin
         total++;
         if (got_d[i] != 9 || got_r[i] != i / 2 || got_c[i] != i % 2) begin
            bad++;
            $display("FAIL ones_out%0d: got %0d@(%0d,%0d) expected 9@(%0d,%0d)",
                     i, got_d[i], got_r[i], got_c[i], i / 2, i % 2);
         end
      end
      total++;
      if (done_cnt != 1) begin bad++; $display("FAIL ones_done_cnt: got %0d expected 1", done_cnt); end
      total++;
      if (done_cyc != 49) begin bad++; $display("FAIL ones_latency: got %0d expected 49", done_cyc); end
      total++;
      if (rd_cnt != 36) begin bad++; $display("FAIL ones_rd_cnt: got %0d expected 36", rd_cnt); end
   endtask

   task automatic test_ramp();
      longint exp_v[4] = '{105, 106, 109, 110};
      for (int i = 0; i < 16; i++) img[i] = 16'(i);
      for (int i = 0; i < 9; i++) wgt[i] = (i == 4) ? 16'sd1 : 16'sd0;
      run_frame(0, 0, 100);
      total++;
      if (tmo || got_d.size() != 4) begin
         bad++;
         $display("FAIL ramp_count: got %0d outputs (timeout=%0d) expected 4", got_d.size(), tmo);
      end
      for (int i = 0; i < got_d.size() && i < 4; i++) begin
         total++;
         if (got_d[i] != exp_v[i]) begin
            bad++;
            $display("FAIL ramp_out%0d: got %0d expected %0d", i, got_d[i], exp_v[i]);
         end
      end
   endtask

   task automatic test_random_frames();
      longint b, e;
      for (int f = 0; f < 3; f++) begin
         load_random();
         b = longint'({$urandom, $urandom}) >>> 20;
         run_frame(1, 0, b);
         total++;
         if (tmo || got_d.size() != 4 || done_cnt != 1) begin
            bad++;
            $display("FAIL rand%0d_frame: got %0d outputs done=%0d timeout=%0d expected 4 outputs done=1",
                     f, got_d.size(), done_cnt, tmo);
         end
         for (int i = 0; i < got_d.size() && i < 4; i++) begin
            e = ref_pix(i / 2, i % 2, b);
            total++;
            if (got_d[i] != e || got_r[i] != i / 2 || got_c[i] != i % 2) begin
               bad++;
               $display("FAIL rand%0d_out%0d: got %0d@(%0d,%0d) expected %0d@(%0d,%0d)",
                        f, i, got_d[i], got_r[i], got_c[i], e, i / 2, i % 2);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      longint b, e;
      load_random();
      b = longint'($urandom_range(0, 5000)) - 2500;
      run_frame(2, 0, b);
      total++;
      if (stab_err) begin bad++; $display("FAIL bp_stable: got unstable output expected stable"); end
      total++;
      if (rd_stall != 0 || rd_cnt != 36) begin
         bad++;
         $display("FAIL bp_rd_en: got %0d total/%0d stalled expected 36/0", rd_cnt, rd_stall);
      end
      total++;
      if (tmo || got_d.size() != 4) begin bad++; $display("FAIL bp_count: got %0d expected 4", got_d.size()); end
      for (int i = 0; i < got_d.size() && i < 4; i++) begin
         e = ref_pix(i / 2, i % 2, b);
         total++;
         if (got_d[i] != e) begin bad++; $display("FAIL bp_out%0d: got %0d expected %0d", i, got_d[i], e); end
      end
   endtask

   task automatic test_reset_midframe();
      int hs, acc_cyc;
      bit hit;
      longint b, e;
      load_random();
      hs = 0; acc_cyc = 0; hit = 0;
      bias = 64'd7;
      start = 1'b1;
      out_ready = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (out_valid && out_ready) hs++;
         else if (hs == 2 && rd_en) begin
            acc_cyc++;
            if (acc_cyc == 4) begin hit = 1; break; end
         end
      end
      total++;
      if (!hit) begin bad++; $display("FAIL rst_mid_reach: got no 3rd-output ACC expected one"); end
      #2 reset = 1'b1;
      #1;
      total++;
      if ({busy, done, rd_en, mac_init_acc, mac_input_valid, out_valid, x_addr, w_addr, out_row, out_col} !== 16'b0
          || {out_data, mac_init_value} !== 128'b0) begin
         bad++;
         $display("FAIL rst_mid_outputs: got busy=%b rd_en=%b x=%0d w=%0d init=%0d expected all 0",
                  busy, rd_en, x_addr, w_addr, mac_init_value);
      end
      #3 reset = 1'b0;
      load_random();
      b = longint'($urandom_range(0, 100000));
      run_frame(0, 0, b);
      total++;
      if (tmo || got_d.size() != 4) begin bad++; $display("FAIL rst_mid_count: got %0d expected 4", got_d.size()); end
      for (int i = 0; i < got_d.size() && i < 4; i++) begin
         e = ref_pix(i / 2, i % 2, b);
         total++;
         if (got_d[i] != e) begin bad++; $display("FAIL rst_mid_out%0d: got %0d expected %0d", i, got_d[i], e); end
      end
   endtask

   task automatic test_start_held();
      load_random();
      run_frame(0, 1, -17);
      total++;
      if (tmo || done_cnt != 1 || got_d.size() != 4) begin
         bad++;
         $display("FAIL held_frames: got done=%0d outputs=%0d expected 1/4", done_cnt, got_d.size());
      end
      total++;
      if (rd_cnt != 36) begin bad++; $display("FAIL held_rd_cnt: got %0d expected 36", rd_cnt); end
      total++;
      if (got_d.size() > 0 && got_d[0] != ref_pix(0, 0, -17)) begin
         bad++;
         $display("FAIL held_out0: got %0d expected %0d", got_d[0], ref_pix(0, 0, -17));
      end
   endtask

   task automatic test_k1();
      longint q[$];
      int     rq[$], cq[$];
      int     cyc, dcnt, dcyc;
      bit     to;
      longint e;
      for (int i = 0; i < 4; i++) img2[i] = 16'sd3;
      wgt2[0] = -16'sd2;
      e = -6;
`ifdef CONV_SCHED_RELU_EN
      e = 0;
`endif
      cyc = 0; dcnt = 0; dcyc = -1; to = 1;
      bias2 = '0;
      out_ready2 = 1'b1;
      start2 = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(posedge clk); #1;
         cyc++;
         start2 = 1'b0;
         if (done2) begin dcnt++; if (dcyc < 0) dcyc = cyc; end
         if (out_valid2 && out_ready2) begin
            q.push_back(longint'(out_data2));
            rq.push_back(int'(out_row2));
            cq.push_back(int'(out_col2));
         end
         if (dcyc >= 0 && cyc >= dcyc + 3) begin to = 0; break; end
      end
      total++;
      if (to || dcnt != 1 || q.size() != 4) begin
         bad++;
         $display("FAIL k1_frame: got done=%0d outputs=%0d timeout=%0d expected 1/4/0", dcnt, q.size(), to);
      end
      total++;
      if (dcyc != 17) begin bad++; $display("FAIL k1_latency: got %0d expected 17", dcyc); end
      for (int i = 0; i < q.size() && i < 4; i++) begin
         total++;
         if (q[i] != e || rq[i] != i / 2 || cq[i] != i % 2) begin
            bad++;
            $display("FAIL k1_out%0d: got %0d@(%0d,%0d) expected %0d@(%0d,%0d)",
                     i, q[i], rq[i], cq[i], e, i / 2, i % 2);
         end
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_ones();
      test_ramp();
      test_random_frames();
      test_backpressure();
      test_reset_midframe();
      test_start_held();
      test_k1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
